// File: rtl/mod_exp_pkg.sv
// Shared types for the modular-exponentiation controller: FSM states, exponent bit index and
// a leading-one finder used when leading-zero skipping is built in.
package mod_exp_pkg;

  // Widest exponent the controller supports; bit_idx_t is sized from it.
  localparam int unsigned MaxExpWidth = 16;

  typedef logic [$clog2(MaxExpWidth)-1:0] bit_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StSqrIssue,
    StSqrWait,
    StMulIssue,
    StMulWait,
    StFinish
  } state_e;

  function automatic bit_idx_t msb_idx(input logic [MaxExpWidth-1:0] v);
    bit_idx_t idx;
    idx = '0;
    for (int unsigned i = 0; i < MaxExpWidth; i++) begin
      if (v[i]) idx = bit_idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/response and external-multiplier signals of mod_exp_ctrl.
// master: requester plus multiplier side; slave: the controller.
interface mod_exp_ctrl_if #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned EXP_WIDTH = 16
);
  logic                 start;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic [WIDTH-1:0]     mm_a;
  logic [WIDTH-1:0]     mm_b;
  logic                 mm_enable;
  logic [WIDTH-1:0]     mm_r;
  logic                 mm_done;

  modport master (
    output start, base, exponent, mm_r, mm_done,
    input  busy, done, result, mm_a, mm_b, mm_enable
  );

  modport slave (
    input  start, base, exponent, mm_r, mm_done,
    output busy, done, result, mm_a, mm_b, mm_enable
  );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external modular multiplier.
// Define MOD_EXP_SKIP_LZ_EN to skip leading zero exponent bits (acc starts at base).
module mod_exp_ctrl
  import mod_exp_pkg::*;
#(
  parameter int unsigned P         = 37,
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned EXP_WIDTH = 16
) (
  input logic           clk,
  input logic           reset,
  mod_exp_ctrl_if.slave bus
);

  if (EXP_WIDTH == 0 || EXP_WIDTH > MaxExpWidth) begin : g_bad_exp_width
    $error("EXP_WIDTH out of range");
  end
  if (P < 3 || (P % 2) == 0) begin : g_bad_modulus
    $error("P must be an odd prime");
  end

  state_e                 r_state, w_state_d;
  logic [WIDTH-1:0]       r_acc, w_acc_d;
  logic [WIDTH-1:0]       r_base, w_base_d;
  logic [MaxExpWidth-1:0] r_exp, w_exp_d;
  bit_idx_t               r_idx, w_idx_d;
  logic [WIDTH-1:0]       r_result, w_result_d;
  logic                   w_last, w_bit;
`ifdef MOD_EXP_SKIP_LZ_EN
  bit_idx_t               w_lz_idx;
`endif

  assign w_last = (r_idx == '0);
  assign w_bit  = r_exp[r_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_acc    <= WIDTH'(1);
      r_base   <= '0;
      r_exp    <= '0;
      r_idx    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_acc    <= w_acc_d;
      r_base   <= w_base_d;
      r_exp    <= w_exp_d;
      r_idx    <= w_idx_d;
      r_result <= w_result_d;
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_base_d   = r_base;
    w_exp_d    = r_exp;
    w_idx_d    = r_idx;
    w_result_d = r_result;
`ifdef MOD_EXP_SKIP_LZ_EN
    w_lz_idx   = msb_idx(MaxExpWidth'(bus.exponent));
`endif
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_base_d = bus.base;
          w_exp_d  = MaxExpWidth'(bus.exponent);
`ifdef MOD_EXP_SKIP_LZ_EN
          if (bus.exponent == '0) begin
            w_acc_d   = WIDTH'(1);
            w_state_d = StFinish;
          end else begin
            // acc = base**1 at the leading one; base < P so no reduction needed
            w_acc_d = bus.base;
            if (w_lz_idx == '0) begin
              w_state_d = StFinish;
            end else begin
              w_idx_d   = w_lz_idx - 1'b1;
              w_state_d = StSqrIssue;
            end
          end
`else
          w_acc_d   = WIDTH'(1);
          w_idx_d   = bit_idx_t'(EXP_WIDTH - 1);
          w_state_d = StSqrIssue;
`endif
        end
      end
      StSqrIssue: w_state_d = StSqrWait;
      StSqrWait: begin
        if (bus.mm_done) begin
          w_acc_d = bus.mm_r;
          if (w_bit) begin
            w_state_d = StMulIssue;
          end else if (w_last) begin
            w_state_d = StFinish;
          end else begin
            w_idx_d   = r_idx - 1'b1;
            w_state_d = StSqrIssue;
          end
        end
      end
      StMulIssue: w_state_d = StMulWait;
      StMulWait: begin
        if (bus.mm_done) begin
          w_acc_d = bus.mm_r;
          if (w_last) begin
            w_state_d = StFinish;
          end else begin
            w_idx_d   = r_idx - 1'b1;
            w_state_d = StSqrIssue;
          end
        end
      end
      StFinish: w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    // Result is captured on entry so it is valid alongside done in StFinish.
    if (w_state_d == StFinish && r_state != StFinish) w_result_d = w_acc_d;
  end

  always_comb begin
    bus.busy      = (r_state != StIdle) && (r_state != StFinish);
    bus.done      = (r_state == StFinish);
    bus.result    = r_result;
    bus.mm_enable = (r_state == StSqrIssue) || (r_state == StMulIssue);
    bus.mm_a      = '0;
    bus.mm_b      = '0;
    if (r_state == StSqrIssue || r_state == StSqrWait) begin
      bus.mm_a = r_acc;
      bus.mm_b = r_acc;
    end else if (r_state == StMulIssue || r_state == StMulWait) begin
      bus.mm_a = r_acc;
      bus.mm_b = r_base;
    end
  end

endmodule

// File: doc/mod_exp_ctrl.md
MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have parameter P, default 37, odd prime modulus; P > 1.
REQ-002 SHALL have parameter WIDTH, default 128, operand/result width; P < 2**WIDTH.
REQ-003 SHALL have parameter EXP_WIDTH, default 16, exponent width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request; sampled only in IDLE.
REQ-007 SHALL have port base  input  WIDTH  base; caller guarantees base < P.
REQ-008 SHALL have port exponent  input  EXP_WIDTH  exponent, unsigned.
REQ-009 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  WIDTH  base**exponent mod P, held until next accepted start.
REQ-012 SHALL have ports mm_a, mm_b  output  WIDTH  operands to the external modular multiplier.
REQ-013 SHALL have port mm_enable  output  1  one-cycle issue pulse to the multiplier.
REQ-014 SHALL have ports mm_r  input  WIDTH and mm_done  input  1  multiplier product and completion.

Function
REQ-015 SHALL latch base and exponent on the cycle start is accepted in IDLE; later input changes have no effect.
REQ-016 SHALL compute left-to-right square-and-multiply: acc=1; for i=EXP_WIDTH-1..0: acc=acc*acc mod P; if exponent[i] then acc=acc*base mod P.
REQ-017 SHALL use states IDLE, SQR_ISSUE, SQR_WAIT, MUL_ISSUE, MUL_WAIT, FINISH.
REQ-018 SHALL transition IDLE->SQR_ISSUE on start; SQR_ISSUE->SQR_WAIT; SQR_WAIT->MUL_ISSUE on mm_done when current bit is 1, else to SQR_ISSUE of the next bit, or FINISH after bit 0; MUL_ISSUE->MUL_WAIT; MUL_WAIT on mm_done -> next bit's SQR_ISSUE, or FINISH after bit 0; FINISH->IDLE.
REQ-019 SHALL pulse mm_enable exactly one cycle in each *_ISSUE state and hold mm_a/mm_b stable from that cycle until mm_done is sampled.
REQ-020 SHALL drive mm_a=mm_b=acc for squaring; mm_a=acc, mm_b=latched base for multiply.
REQ-021 SHALL load acc from mm_r in the cycle mm_done is sampled high in a *_WAIT state; mm_done in any other state is ignored.
REQ-022 SHALL wait indefinitely in *_WAIT states for mm_done (no timeout).
REQ-023 SHALL in FINISH register result=acc and pulse done; busy deasserts in the same cycle done pulses.
REQ-024 SHALL ignore start while busy; start coincident with done (FINISH) is ignored.
REQ-025 SHALL return result=1 for exponent=0.

Reset
REQ-026 SHALL on reset, including mid-operation, go to IDLE with busy=0, done=0, mm_enable=0, mm_a=0, mm_b=0, result=0, acc=1.
REQ-027 SHALL discard an in-flight multiplication on reset; a late mm_done after reset is ignored.

Configuration
REQ-028 SHALL with MOD_EXP_SKIP_LZ_EN defined skip leading zero exponent bits: at the most significant set bit acc is loaded with base with no multiplier operations, iteration continues from the next lower bit; exponent=0 goes directly to FINISH with result=1 and zero mm_enable pulses.
REQ-029 SHALL without MOD_EXP_SKIP_LZ_EN process all EXP_WIDTH bits (EXP_WIDTH squarings + popcount(exponent) multiplies), giving exponent-value-independent squaring count.

Structure
REQ-030 SHALL place the state enum and a bit-index type sized $clog2(EXP_WIDTH) in shared package mod_exp_pkg.
REQ-031 SHALL contain no sub-module; the modular multiplier is instantiated beside it at the parent level and connected via mm_* ports.

Verification
REQ-032 SHALL verify P=37, EXP_WIDTH=8, base=3, exponent=5 -> result=21, done once; 10 mm_enable pulses (3 with MOD_EXP_SKIP_LZ_EN).
REQ-033 SHALL verify base=36, exponent=2 -> result=1; base=5, exponent=1 -> result=5.
REQ-034 SHALL verify exponent=0 -> result=1; 8 mm_enable pulses without macro, 0 with it.
REQ-035 SHALL verify a multiplier model with random 1-20 cycle latency and spurious mm_done in IDLE -> results unchanged, spurious pulses ignored.
REQ-036 SHALL verify reset asserted during MUL_WAIT, then late mm_done -> all outputs at reset values, no done pulse; next start with base=2, exponent=10 -> result=25.
REQ-037 SHALL verify start pulsed while busy -> ignored, original result delivered, single done.
